// File: rtl/led_mode_ctrl.sv
// LED bank mode controller: req/ack mode changes, static/blink/chase/alternate patterns
// paced by one shared prescaler. Define LED_ACTIVE_LOW_EN for inverted LED drive.
module led_mode_ctrl #(
    parameter int CLK_FREQ = 50000000,
    parameter int NUM_LED  = 4,
    parameter int FAST_HZ  = 4,
    parameter int SLOW_HZ  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               mode_req,
    input  logic [2:0]         mode_sel,
    output logic               mode_ack,
    output logic               mode_err,
    output logic [2:0]         cur_mode,
    output logic               fast_tick,
    output logic [NUM_LED-1:0] led
);

    localparam int FAST_DIV = CLK_FREQ / (2 * FAST_HZ);
    localparam int SLOW_DIV = FAST_HZ / SLOW_HZ;
    localparam int PRE_W    = (FAST_DIV > 1) ? $clog2(FAST_DIV) : 1;
    localparam int SLOW_W   = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(FAST_DIV - 1);
    localparam logic [SLOW_W-1:0] SLOW_LAST = SLOW_W'(SLOW_DIV - 1);

    if ((CLK_FREQ % (2 * FAST_HZ)) != 0 || (FAST_HZ % SLOW_HZ) != 0 || FAST_DIV < 2
        || NUM_LED < 2) begin : g_param_err
        $error("led_mode_ctrl: rates must divide exactly, FAST_DIV >= 2, NUM_LED >= 2");
    end

    typedef enum logic [2:0] {
        MODE_OFF        = 3'd0,
        MODE_ON         = 3'd1,
        MODE_BLINK_SLOW = 3'd2,
        MODE_BLINK_FAST = 3'd3,
        MODE_CHASE      = 3'd4,
        MODE_ALTERNATE  = 3'd5
    } mode_e;

    mode_e              cur_mode_q, cur_mode_d;
    logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d;
    logic [SLOW_W-1:0]  slow_cnt_q, slow_cnt_d;
    logic [NUM_LED-1:0] led_q, led_d;
    logic               mode_ack_q, mode_ack_d;
    logic               mode_err_q, mode_err_d;
    logic               fast_tick_q, fast_tick_d;

    logic [NUM_LED-1:0] alt_pat;
    logic [NUM_LED-1:0] entry_pat;
    logic               accept, sel_valid, fast_hit, slow_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LED; gi++) begin : g_alt
            assign alt_pat[gi] = ((gi % 2) == 0) ? 1'b1 : 1'b0;
        end
    endgenerate

    // A pending request is only taken while running and not on the cycle right after an ack.
    assign accept    = enable & mode_req & ~mode_ack_q;
    assign sel_valid = (mode_sel <= 3'd5);
    assign fast_hit  = enable & (pre_cnt_q == PRE_LAST);
    assign slow_hit  = fast_hit & (slow_cnt_q == SLOW_LAST);

    always_comb begin
        entry_pat = '0;
        case (mode_sel)
            3'd1, 3'd2, 3'd3: entry_pat = '1;
            3'd4:             entry_pat = NUM_LED'(1);
            3'd5:             entry_pat = alt_pat;
            default:          entry_pat = '0;
        endcase
    end

    always_comb begin
        cur_mode_d  = cur_mode_q;
        pre_cnt_d   = pre_cnt_q;
        slow_cnt_d  = slow_cnt_q;
        led_d       = led_q;
        mode_ack_d  = 1'b0;
        mode_err_d  = 1'b0;
        fast_tick_d = 1'b0;

        if (enable) begin
            pre_cnt_d   = fast_hit ? '0 : pre_cnt_q + PRE_W'(1);
            fast_tick_d = fast_hit;
            if (fast_hit) begin
                slow_cnt_d = slow_hit ? '0 : slow_cnt_q + SLOW_W'(1);
            end

            case (cur_mode_q)
                MODE_BLINK_SLOW: if (slow_hit) led_d = ~led_q;
                MODE_BLINK_FAST: if (fast_hit) led_d = ~led_q;
                MODE_CHASE:      if (fast_hit) led_d = {led_q[NUM_LED-2:0], led_q[NUM_LED-1]};
                MODE_ALTERNATE:  if (slow_hit) led_d = ~led_q;
                default:         led_d = led_q;
            endcase

            // A valid request overrides any coincident tick: pattern and timebase restart.
            if (accept) begin
                mode_ack_d = 1'b1;
                if (sel_valid) begin
                    cur_mode_d  = mode_e'(mode_sel);
                    pre_cnt_d   = '0;
                    slow_cnt_d  = '0;
                    led_d       = entry_pat;
                    fast_tick_d = 1'b0;
                end else begin
                    mode_err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_mode_q  <= MODE_OFF;
            pre_cnt_q   <= '0;
            slow_cnt_q  <= '0;
            led_q       <= '0;
            mode_ack_q  <= 1'b0;
            mode_err_q  <= 1'b0;
            fast_tick_q <= 1'b0;
        end else begin
            cur_mode_q  <= cur_mode_d;
            pre_cnt_q   <= pre_cnt_d;
            slow_cnt_q  <= slow_cnt_d;
            led_q       <= led_d;
            mode_ack_q  <= mode_ack_d;
            mode_err_q  <= mode_err_d;
            fast_tick_q <= fast_tick_d;
        end
    end

    assign cur_mode  = cur_mode_q;
    assign mode_ack  = mode_ack_q;
    assign mode_err  = mode_err_q;
    assign fast_tick = fast_tick_q;

`ifdef LED_ACTIVE_LOW_EN
    assign led = ~led_q;
`else
    assign led = led_q;
`endif

endmodule

// File: doc/led_mode_ctrl.md
Name: led_mode_ctrl

Overview:
Mode controller for the board LED bank. It accepts mode-change requests over a req/ack handshake and sequences NUM_LED outputs through static, blink, chase and alternate patterns. All pattern timing comes from one shared prescaler derived from CLK_FREQ. It sits between the user/command logic (buttons, UART decoder) and the LED pins.

Parameters:
CLK_FREQ, 50000000, input clock frequency in Hz
NUM_LED, 4, number of LED outputs (min 2)
FAST_HZ, 4, fast toggle rate in Hz
SLOW_HZ, 1, slow toggle rate in Hz
- Derived: FAST_DIV = CLK_FREQ/(2*FAST_HZ); SLOW_DIV = FAST_HZ/SLOW_HZ.
- Counter widths sized with $clog2.
- Elaboration error unless both divisions are exact and FAST_DIV >= 2.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
enable  input  1  1 = run; 0 = freeze counters, LEDs and request acceptance
mode_req  input  1  mode change request (level, held until mode_ack)
mode_sel  input  3  requested mode, sampled on acceptance
mode_ack  output  1  one-cycle pulse, request accepted
mode_err  output  1  one-cycle pulse with mode_ack, mode_sel invalid
cur_mode  output  3  active mode
fast_tick  output  1  one-cycle pulse at each fast half-period
led  output  NUM_LED  LED drive, 1 = lit

Behaviour:
- Reset (rst=0, async): cur_mode=0 (OFF), led=0, mode_ack=0, mode_err=0, fast_tick=0, all counters 0.
- Modes:
  - 0 OFF: led all 0
  - 1 ON: led all 1
  - 2 BLINK_SLOW: all LEDs, toggle on slow tick
  - 3 BLINK_FAST: all LEDs, toggle on fast tick
  - 4 CHASE: one-hot, rotate left on fast tick
  - 5 ALTERNATE: even/odd bits, invert on slow tick
  - 6,7 invalid
- Acceptance:
  - Condition: rising edge where mode_req=1, enable=1 and mode_ack=0.
  - At that edge (E0):
    - mode_ack=1 for that cycle.
    - Valid code: cur_mode=mode_sel; pre_cnt=0; slow_cnt=0; led loads the entry pattern.
    - Entry patterns: OFF all 0; ON/BLINK all 1; CHASE bit0 only; ALTERNATE even bits 1 (e.g. 4'b0101).
    - Invalid code: mode_err=1 with mode_ack; cur_mode, led and counters unchanged (no counter reset).
  - mode_ack=1 blocks re-acceptance on the next edge. The requester drops mode_req after seeing ack.
  - Latency: request held at E0 -> ack and new pattern visible after E0, i.e. 1 cycle.
  - Re-selecting the current mode is valid: it restarts the pattern and counters.
- Prescaler (enable=1 only):
  - pre_cnt increments each edge.
  - At pre_cnt==FAST_DIV-1 it wraps to 0 and a fast tick occurs. The fast_tick output is high for the cycle after that edge.
  - slow_cnt counts fast ticks. At slow_cnt==SLOW_DIV-1 coincident with a fast tick, it wraps and a slow tick occurs.
  - First fast update lands FAST_DIV edges after E0; first slow update lands FAST_DIV*SLOW_DIV edges after E0.
- Pattern updates occur at the tick edge. OFF and ON ignore ticks. CHASE wraps bit NUM_LED-1 -> bit0.
- enable=0: pre_cnt, slow_cnt, led and cur_mode hold; fast_tick=0; mode_req ignored, no ack. Resuming continues from the held counts.
- Simultaneous request and tick edge: the request wins. The entry pattern loads and counters reset; the tick update is discarded.
- Reset mid-pattern: immediate return to reset values. A pending mode_req is re-evaluated after rst releases.

Optional Feature:
LED_ACTIVE_LOW_EN
- Defined: led port is the bitwise inverse of the internal pattern, including the reset value (all 1).
- Undefined: led is active-high as described above.
- cur_mode, fast_tick, mode_ack and mode_err are unaffected.

Test Plan:
All scenarios use CLK_FREQ=16, FAST_HZ=4, SLOW_HZ=1, NUM_LED=4, giving FAST_DIV=2 and SLOW_DIV=4.
- Reset and ON:
  - Stimulus: release rst, enable=1, request mode 1.
  - Required: led=0000 and cur_mode=0 before the request; mode_ack pulses once; led=1111 thereafter, unchanging for 20 cycles.
- BLINK_FAST:
  - Stimulus: request mode 3.
  - Required: led=1111 after E0; toggles to 0000 at E0+2, 1111 at E0+4; fast_tick pulses every 2 cycles.
- CHASE wrap:
  - Stimulus: request mode 4.
  - Required: led=0001, 0010, 0100, 1000, 0001 at E0, E0+2, +4, +6, +8.
- ALTERNATE and enable freeze:
  - Stimulus: request mode 5; drop enable at E0+5 for 10 cycles, then restore it.
  - Required: led=0101 at E0 and inverts at E0+8, shifted by the freeze length, i.e. at E0+18.
  - Required: no fast_tick pulses while enable=0.
- Invalid code:
  - Stimulus: request mode_sel=7 while in BLINK_SLOW.
  - Required: mode_ack and mode_err both pulse for 1 cycle; cur_mode stays 2; blink phase is not restarted.
- Request held and async reset:
  - Stimulus: hold mode_req=1 with mode 4 for 6 cycles.
  - Required: exactly one ack per 2-cycle window (ack, gap, ack...) with the pattern restarting on each ack.
  - Stimulus: assert rst mid-cycle.
  - Required: led=0000 and cur_mode=0 immediately, without waiting for a clock edge.
  - With LED_ACTIVE_LOW_EN defined: led=1111 in reset.
